fir_coef_bank: RTL and testbench
================================

// Module: fir_coef_bank
// PURPOSE
//  Runtime-loadable, multi-bank FIR coefficient store. Replaces the fixed low/high-pass coefficient ROM.
//  Holds NBANKS sets of TAPS signed coefficients and serves reads to the FIR MAC engine with 1-cycle latency.
//  Switches the active bank only at a frame (sample) boundary, so a MAC pass never mixes two coefficient sets.
//  Bank convention: bank 0 = low-pass, bank 1 = high-pass; further banks are free.
// PARAMETERS
//  COEF_W  16  coefficient width, two's complement
//  TAPS    32  coefficients per bank; must be a power of 2
//  ADDR_W  5   log2(TAPS)
//  NBANKS  4   number of coefficient banks; must be >= 2
//  BANK_W  2   log2(NBANKS)
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst          in   1       synchronous, active-high reset
//  rd_en        in   1       read request from the MAC engine
//  rd_addr      in   ADDR_W  tap index to read
//  rd_data      out  COEF_W  coefficient, registered
//  frame_start  in   1       1-cycle pulse at the start of each MAC pass
//  bank_sel     in   BANK_W  requested playback bank (mode select)
//  active_bank  out  BANK_W  bank currently used by reads
//  coef_valid   out  NBANKS  per-bank "contents loaded" flags
//  ld_start     in   1       begin loading bank ld_bank
//  ld_bank      in   BANK_W  target bank for the load
//  ld_valid     in   1       ld_data is valid
//  ld_data      in   COEF_W  coefficient word; tap 0 first
//  ld_ready     out  1       high while in LOAD state
//  ld_done      out  1       1-cycle pulse when a load completes
//  ld_err       out  1       1-cycle pulse when ld_start is rejected
// BEHAVIOUR
//  Reset values: rd_data=0, active_bank=0, coef_valid=0, ld_ready=0, ld_done=0, ld_err=0, FSM=IDLE.
//  RAM contents are not cleared by rst; coef_valid gates their use.
//  Read path:
//   - rd_en: rd_data <= coef_valid[eff_bank] ? mem[eff_bank][rd_addr] : 0 on the next edge.
//   - No rd_en: rd_data holds its value.
//  Effective bank and switching:
//   - eff_bank = nxt_bank when frame_start=1, else active_bank.
//   - nxt_bank = bank_sel when bank_sel!=active_bank and coef_valid[bank_sel]=1; otherwise active_bank.
//   - active_bank <= nxt_bank only on frame_start. A read in the frame_start cycle already uses the new bank.
//   - A request for an unloaded bank stays pending. It takes effect at the first frame_start after that bank's load completes.
//  Load FSM, states IDLE and LOAD:
//   - IDLE, ld_start:
//     - Rejected when ld_bank==active_bank or ld_bank==bank_sel: ld_err=1 for one cycle, stay in IDLE.
//     - Otherwise: clear coef_valid[ld_bank], wr_cnt<=0, go to LOAD.
//   - LOAD: ld_ready=1. Each cycle with ld_valid=1 writes ld_data to mem[ld_bank_q][wr_cnt] and increments wr_cnt.
//   - On the write with wr_cnt==TAPS-1: set coef_valid[ld_bank_q], ld_done=1 for one cycle, return to IDLE.
//     ld_ready is 0 in the following cycle.
//   - ld_start while in LOAD is ignored; no error.
//   - ld_bank is latched at ld_start (ld_bank_q).
//   - rst during LOAD: return to IDLE and clear all coef_valid; a partial load is never marked valid.
//  Simultaneous events:
//   - Load writes and reads never target the same bank.
//   - frame_start plus ld_done on the same cycle: the switch does not see the new valid bit. It takes effect at the next frame_start.
//  Widths: data stored and returned unmodified; no scaling or sign extension.
// TESTING
//  1. Reset, rd_en on bank 0 -> rd_data=0, coef_valid=4'b0000, active_bank=0.
//  2. Load bank 1 with 0x0001..0x0020, then bank_sel=1 and a frame_start -> active_bank=1; rd_addr=5 gives 0x0006 one cycle later.
//  3. bank_sel=2 (unloaded) plus frame_start -> active_bank unchanged.
//     Load bank 2, next frame_start -> active_bank=2.
//  4. ld_start with ld_bank==active_bank -> ld_err pulse, ld_ready stays 0, coef_valid unchanged.
//  5. Gapped ld_valid (1 of 3 cycles) over 32 words -> ld_done exactly after the 32nd accepted word; all 32 words read back correctly.
//  6. rst after 10 load words -> FSM in IDLE, coef_valid=0, ld_ready=0; rd_data=0 for every bank.

Source files
------------

// File: rtl/fir_coef_bank.sv
// Multi-bank, runtime-loadable FIR coefficient store with 1-cycle registered reads.
// The active bank changes only on frame_start, so one MAC pass always uses a single coefficient set.
module fir_coef_bank #(
    parameter int COEF_W = 16,
    parameter int TAPS   = 32,
    parameter int ADDR_W = 5,
    parameter int NBANKS = 4,
    parameter int BANK_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [COEF_W-1:0] rd_data,
    input  logic              frame_start,
    input  logic [BANK_W-1:0] bank_sel,
    output logic [BANK_W-1:0] active_bank,
    output logic [NBANKS-1:0] coef_valid,
    input  logic              ld_start,
    input  logic [BANK_W-1:0] ld_bank,
    input  logic              ld_valid,
    input  logic [COEF_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_err
);

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]        wr_cnt_q, wr_cnt_d;
    logic [BANK_W-1:0]        ld_bank_q, ld_bank_d;
    logic [BANK_W-1:0]        active_bank_q, active_bank_d;
    logic [NBANKS-1:0]        coef_valid_q, coef_valid_d;
    logic [COEF_W-1:0]        rd_data_q, rd_data_d;
    logic [BANK_W-1:0]        nxt_bank;
    logic [BANK_W-1:0]        eff_bank;
    logic                     mem_we;
    logic [BANK_W+ADDR_W-1:0] mem_waddr;
    logic                     ld_done_d;
    logic                     ld_err_d;

    logic [COEF_W-1:0] mem [NBANKS*TAPS];

    // Bank switch uses the registered valid bits, so a load finishing this cycle is seen one frame later.
    always_comb begin
        nxt_bank = active_bank_q;
        if ((bank_sel != active_bank_q) && coef_valid_q[bank_sel]) begin
            nxt_bank = bank_sel;
        end
        eff_bank      = frame_start ? nxt_bank : active_bank_q;
        active_bank_d = eff_bank;
        rd_data_d     = rd_data_q;
        if (rd_en) begin
            rd_data_d = coef_valid_q[eff_bank] ? mem[{eff_bank, rd_addr}] : '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        ld_bank_d    = ld_bank_q;
        coef_valid_d = coef_valid_q;
        mem_we       = 1'b0;
        ld_done_d    = 1'b0;
        ld_err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ld_start) begin
                    if ((ld_bank == active_bank_q) || (ld_bank == bank_sel)) begin
                        ld_err_d = 1'b1;
                    end else begin
                        coef_valid_d[ld_bank] = 1'b0;
                        wr_cnt_d              = '0;
                        ld_bank_d             = ld_bank;
                        state_d               = LOAD;
                    end
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    mem_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                    if (wr_cnt_q == ADDR_W'(TAPS - 1)) begin
                        coef_valid_d[ld_bank_q] = 1'b1;
                        ld_done_d               = 1'b1;
                        state_d                 = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_waddr = {ld_bank_q, wr_cnt_q};

    // Coefficient RAM is deliberately not reset; coef_valid decides whether contents may be used.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_cnt_q      <= '0;
            ld_bank_q     <= '0;
            active_bank_q <= '0;
            coef_valid_q  <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            ld_bank_q     <= ld_bank_d;
            active_bank_q <= active_bank_d;
            coef_valid_q  <= coef_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign active_bank = active_bank_q;
    assign coef_valid  = coef_valid_q;
    assign ld_ready    = (state_q == LOAD);
    assign ld_done     = ld_done_d && !rst;
    assign ld_err      = ld_err_d && !rst;

endmodule

// File: tb/tb_fir_coef_bank.sv
// Self-checking bench for fir_coef_bank: directed scenarios plus randomized traffic
// compared against an array-based behavioural model of the coefficient store.
module tb_fir_coef_bank;

    localparam int COEF_W = 16;
    localparam int TAPS   = 32;
    localparam int ADDR_W = 5;
    localparam int NBANKS = 4;
    localparam int BANK_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [COEF_W-1:0] rd_data;
    logic              frame_start;
    logic [BANK_W-1:0] bank_sel;
    logic [BANK_W-1:0] active_bank;
    logic [NBANKS-1:0] coef_valid;
    logic              ld_start;
    logic [BANK_W-1:0] ld_bank;
    logic              ld_valid;
    logic [COEF_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic              ld_err;

    int total = 0;
    int bad   = 0;

    logic [COEF_W-1:0] m_mem [NBANKS][TAPS];
    logic [NBANKS-1:0] m_valid;
    int                m_act;
    bit                m_loading;
    int                m_cnt;
    int                m_lb;
    logic [COEF_W-1:0] m_rd;
    bit                exp_done;
    bit                exp_err;
    logic              seen_done;
    logic              seen_err;

    fir_coef_bank #(
        .COEF_W(COEF_W), .TAPS(TAPS), .ADDR_W(ADDR_W), .NBANKS(NBANKS), .BANK_W(BANK_W)
    ) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_start(frame_start), .bank_sel(bank_sel), .active_bank(active_bank),
        .coef_valid(coef_valid), .ld_start(ld_start), .ld_bank(ld_bank),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_done(ld_done), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    // One clock of the reference behaviour, evaluated from the inputs applied during the cycle.
    task automatic model_step();
        int nb;
        int eb;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (rst) begin
            m_valid   = '0;
            m_act     = 0;
            m_rd      = '0;
            m_loading = 1'b0;
            m_cnt     = 0;
            return;
        end
        nb = ((int'(bank_sel) != m_act) && m_valid[bank_sel]) ? int'(bank_sel) : m_act;
        eb = frame_start ? nb : m_act;
        if (rd_en) m_rd = m_valid[eb] ? m_mem[eb][rd_addr] : '0;
        if (m_loading) begin
            if (ld_valid) begin
                m_mem[m_lb][m_cnt] = ld_data;
                if (m_cnt == TAPS - 1) begin
                    m_valid[m_lb] = 1'b1;
                    m_loading     = 1'b0;
                    exp_done      = 1'b1;
                end
                m_cnt++;
            end
        end else if (ld_start) begin
            if ((int'(ld_bank) == m_act) || (ld_bank == bank_sel)) begin
                exp_err = 1'b1;
            end else begin
                m_valid[ld_bank] = 1'b0;
                m_loading        = 1'b1;
                m_cnt            = 0;
                m_lb             = int'(ld_bank);
            end
        end
        if (frame_start) m_act = nb;
    endtask

    task automatic tick();
        @(negedge clk);
        seen_done = ld_done;
        seen_err  = ld_err;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int bank, input int gap, input int sel_during, input bit fs_last,
                           input bit seq_data, output int done_cnt, output int done_at,
                           output int err_cnt, output int ready_bad);
        int words;
        ld_start = 1'b1;
        ld_bank  = BANK_W'(bank);
        tick();
        ld_start  = 1'b0;
        bank_sel  = BANK_W'(sel_during);
        words     = 0;
        done_cnt  = 0;
        done_at   = -1;
        err_cnt   = 0;
        ready_bad = (ld_ready !== 1'b1) ? 1 : 0;
        for (int c = 0; (c < TAPS * (gap + 1) + 4) && (words < TAPS); c++) begin
            ld_valid    = ((c % (gap + 1)) == gap);
            ld_start    = (gap > 0) && !ld_valid;
            ld_bank     = BANK_W'(m_act);
            ld_data     = seq_data ? COEF_W'(words + 1) : COEF_W'($urandom);
            frame_start = fs_last && ld_valid && (words == TAPS - 1);
            if (ld_valid) words++;
            tick();
            if (seen_done) begin
                done_cnt++;
                done_at = words;
            end
            if (seen_err) err_cnt++;
            if ((words < TAPS) && (ld_ready !== 1'b1)) ready_bad++;
        end
        ld_valid    = 1'b0;
        ld_start    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_en = 1'b0; rd_addr = '0; frame_start = 1'b0; bank_sel = '0;
        ld_start = 1'b0; ld_bank = '0; ld_valid = 1'b0; ld_data = '0;
        tick();
        tick();
        rst = 1'b0;
        rd_en = 1'b1;
        rd_addr = ADDR_W'($urandom);
        tick();
        rd_en = 1'b0;
        total++; if (rd_data !== '0) begin bad++; $display("[TB] FAIL reset_rd_data: got %0h want 0", rd_data); end
        total++; if (coef_valid !== 4'b0000) begin bad++; $display("[TB] FAIL reset_coef_valid: got %b want 0000", coef_valid); end
        total++; if (active_bank !== 2'd0) begin bad++; $display("[TB] FAIL reset_active_bank: got %0d want 0", active_bank); end
        total++; if (ld_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ld_ready: got %b want 0", ld_ready); end
    endtask

    task automatic test_load_switch();
        int dc, da, ec, rb;
        bank_sel = 2'd0;
        do_load(1, 0, 0, 1'b0, 1'b1, dc, da, ec, rb);
        total++; if (dc !== 1) begin bad++; $display("[TB] FAIL load1_done_count: got %0d want 1", dc); end
        total++; if (da !== TAPS) begin bad++; $display("[TB] FAIL load1_done_word: got %0d want %0d", da, TAPS); end
        total++; if (rb !== 0) begin bad++; $display("[TB] FAIL load1_ready_drops: got %0d want 0", rb); end
        total++; if (coef_valid !== 4'b0010) begin bad++; $display("[TB] FAIL load1_coef_valid: got %b want 0010", coef_valid); end
        total++; if (ld_ready !== 1'b0) begin bad++; $display("[TB] FAIL load1_ready_after: got %b want 0", ld_ready); end
        bank_sel = 2'd1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        total++; if (active_bank !== 2'd1) begin bad++; $display("[TB] FAIL switch_to_1: got %0d want 1", active_bank); end
        rd_en = 1'b1;
        rd_addr = 5'd5;
        tick();
        rd_en = 1'b0;
        total++; if (rd_data !== 16'h0006) begin bad++; $display("[TB] FAIL read_b1_a5: got %0h want 6", rd_data); end
    endtask

    task automatic test_pending();
        int dc, da, ec, rb;
        bank_sel = 2'd2;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        total++; if (active_bank !== 2'd1) begin bad++; $display("[TB] FAIL pending_unloaded: got %0d want 1", active_bank); end
        ld_start = 1'b1;
        ld_bank = 2'd2;
        tick();
        ld_start = 1'b0;
        total++; if (seen_err !== 1'b1) begin bad++; $display("[TB] FAIL err_bank_sel: got %b want 1", seen_err); end
        total++; if (ld_ready !== 1'b0) begin bad++; $display("[TB] FAIL err_bank_sel_ready: got %b want 0", ld_ready); end
        bank_sel = 2'd1;
        do_load(2, 0, 2, 1'b1, 1'b0, dc, da, ec, rb);
        total++; if (da !== TAPS) begin bad++; $display("[TB] FAIL load2_done_word: got %0d want %0d", da, TAPS); end
        total++; if (active_bank !== 2'd1) begin bad++; $display("[TB] FAIL same_cycle_done_switch: got %0d want 1", active_bank); end
        total++; if (coef_valid !== 4'b0110) begin bad++; $display("[TB] FAIL load2_coef_valid: got %b want 0110", coef_valid); end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        total++; if (active_bank !== 2'd2) begin bad++; $display("[TB] FAIL pending_takes_effect: got %0d want 2", active_bank); end
    endtask

    task automatic test_reject();
        logic [NBANKS-1:0] cv;
        cv = coef_valid;
        ld_start = 1'b1;
        ld_bank = active_bank;
        tick();
        ld_start = 1'b0;
        total++; if (seen_err !== 1'b1) begin bad++; $display("[TB] FAIL err_active: got %b want 1", seen_err); end
        total++; if (ld_ready !== 1'b0) begin bad++; $display("[TB] FAIL err_active_ready: got %b want 0", ld_ready); end
        total++; if (coef_valid !== cv) begin bad++; $display("[TB] FAIL err_active_valid: got %b want %b", coef_valid, cv); end
        tick();
        total++; if (seen_err !== 1'b0) begin bad++; $display("[TB] FAIL err_pulse_width: got %b want 0", seen_err); end
    endtask

    task automatic test_gapped();
        int dc, da, ec, rb;
        do_load(0, 2, 2, 1'b0, 1'b0, dc, da, ec, rb);
        total++; if (dc !== 1) begin bad++; $display("[TB] FAIL gap_done_count: got %0d want 1", dc); end
        total++; if (da !== TAPS) begin bad++; $display("[TB] FAIL gap_done_word: got %0d want %0d", da, TAPS); end
        total++; if (ec !== 0) begin bad++; $display("[TB] FAIL gap_start_in_load_err: got %0d want 0", ec); end
        total++; if (rb !== 0) begin bad++; $display("[TB] FAIL gap_ready_drops: got %0d want 0", rb); end
        total++; if (coef_valid !== 4'b0111) begin bad++; $display("[TB] FAIL gap_coef_valid: got %b want 0111", coef_valid); end
        bank_sel = 2'd0;
        frame_start = 1'b1;
        rd_en = 1'b1;
        rd_addr = '0;
        tick();
        frame_start = 1'b0;
        total++; if (active_bank !== 2'd0) begin bad++; $display("[TB] FAIL gap_switch_to_0: got %0d want 0", active_bank); end
        total++; if (rd_data !== m_mem[0][0]) begin bad++; $display("[TB] FAIL gap_read_switch_cycle: got %0h want %0h", rd_data, m_mem[0][0]); end
        for (int a = 1; a < TAPS; a++) begin
            rd_addr = ADDR_W'(a);
            tick();
            total++;
            if (rd_data !== m_mem[0][a]) begin
                bad++;
                $display("[TB] FAIL gap_readback[%0d]: got %0h want %0h", a, rd_data, m_mem[0][a]);
            end
        end
        rd_en = 1'b0;
        rd_addr = ADDR_W'($urandom);
        tick();
        total++; if (rd_data !== m_mem[0][TAPS-1]) begin bad++; $display("[TB] FAIL rd_hold: got %0h want %0h", rd_data, m_mem[0][TAPS-1]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bank_sel    = BANK_W'($urandom_range(0, NBANKS - 1));
            frame_start = ($urandom % 4) == 0;
            rd_en       = ($urandom % 2) == 0;
            rd_addr     = ADDR_W'($urandom);
            ld_start    = ($urandom % 12) == 0;
            ld_bank     = BANK_W'($urandom_range(0, NBANKS - 1));
            ld_valid    = ($urandom % 3) != 0;
            ld_data     = COEF_W'($urandom);
            tick();
            total++; if (rd_data !== m_rd) begin bad++; $display("[TB] FAIL rnd_rd_data@%0d: got %0h want %0h", i, rd_data, m_rd); end
            total++; if (active_bank !== BANK_W'(m_act)) begin bad++; $display("[TB] FAIL rnd_active@%0d: got %0d want %0d", i, active_bank, m_act); end
            total++; if (coef_valid !== m_valid) begin bad++; $display("[TB] FAIL rnd_valid@%0d: got %b want %b", i, coef_valid, m_valid); end
            total++; if (ld_ready !== m_loading) begin bad++; $display("[TB] FAIL rnd_ready@%0d: got %b want %b", i, ld_ready, m_loading); end
            total++; if (seen_done !== exp_done) begin bad++; $display("[TB] FAIL rnd_done@%0d: got %b want %b", i, seen_done, exp_done); end
            total++; if (seen_err !== exp_err) begin bad++; $display("[TB] FAIL rnd_err@%0d: got %b want %b", i, seen_err, exp_err); end
        end
        ld_start = 1'b0;
        frame_start = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; (i < 2 * TAPS) && m_loading; i++) begin
            ld_valid = 1'b1;
            ld_data  = COEF_W'($urandom);
            tick();
        end
        ld_valid = 1'b0;
        total++; if (ld_ready !== 1'b0) begin bad++; $display("[TB] FAIL rnd_drain_ready: got %b want 0", ld_ready); end
    endtask

    task automatic test_reset_during_load();
        bank_sel = BANK_W'(m_act);
        ld_start = 1'b1;
        ld_bank  = BANK_W'((m_act + 1) % NBANKS);
        tick();
        ld_start = 1'b0;
        for (int w = 0; w < 10; w++) begin
            ld_valid = 1'b1;
            ld_data  = COEF_W'($urandom);
            tick();
        end
        ld_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (ld_ready !== 1'b0) begin bad++; $display("[TB] FAIL rstload_ready: got %b want 0", ld_ready); end
        total++; if (coef_valid !== 4'b0000) begin bad++; $display("[TB] FAIL rstload_valid: got %b want 0000", coef_valid); end
        total++; if (active_bank !== 2'd0) begin bad++; $display("[TB] FAIL rstload_active: got %0d want 0", active_bank); end
        for (int b = 0; b < NBANKS; b++) begin
            bank_sel    = BANK_W'(b);
            frame_start = 1'b1;
            rd_en       = 1'b1;
            rd_addr     = ADDR_W'($urandom);
            tick();
            total++;
            if (rd_data !== '0) begin
                bad++;
                $display("[TB] FAIL rstload_read_bank%0d: got %0h want 0", b, rd_data);
            end
        end
        frame_start = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_switch();
        test_pending();
        test_reject();
        test_gapped();
        test_random();
        test_reset_during_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
